// File: rtl/switch_allocator.sv
// XY-routed switch allocator: per-output round-robin over the five input FIFO heads, pops winners into 16-bit output registers.
// Latency: a head granted in cycle t is on its output with valid at cycle t+1; pops are combinational in cycle t.
// Backpressure: an output loads only when empty or being drained; blocked requesters keep their head and retry.
module switch_allocator #(
    parameter int X_ID = 0,
    parameter int Y_ID = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] north_i,
    input  logic [15:0] south_i,
    input  logic [15:0] east_i,
    input  logic [15:0] west_i,
    input  logic [15:0] local_i,
    input  logic        valid_n_i,
    input  logic        valid_s_i,
    input  logic        valid_e_i,
    input  logic        valid_w_i,
    input  logic        valid_l_i,
    output logic        pop_req_n_o,
    output logic        pop_req_s_o,
    output logic        pop_req_e_o,
    output logic        pop_req_w_o,
    output logic        pop_req_l_o,
    output logic [15:0] north_o,
    output logic [15:0] south_o,
    output logic [15:0] east_o,
    output logic [15:0] west_o,
    output logic [15:0] local_o,
    output logic        valid_n_o,
    output logic        valid_s_o,
    output logic        valid_e_o,
    output logic        valid_w_o,
    output logic        valid_l_o,
    input  logic        ready_n_i,
    input  logic        ready_s_i,
    input  logic        ready_e_i,
    input  logic        ready_w_i,
    input  logic        ready_l_i
);

    localparam logic [2:0] MY_X = X_ID[2:0];
    localparam logic [2:0] MY_Y = Y_ID[2:0];

    logic [15:0] in_flit [5];
    logic [4:0]  in_vld;
    logic [4:0]  out_rdy;
    logic [4:0]  req_oh  [5];
    logic [4:0]  can_load;
    logic [4:0]  gnt_vld;
    logic [2:0]  gnt_idx [5];
    logic [4:0]  pop_c;
    logic [2:0]  rr_ptr  [5];
    logic [15:0] out_dat [5];
    logic [4:0]  out_vld;

    assign in_flit[0] = north_i;
    assign in_flit[1] = south_i;
    assign in_flit[2] = east_i;
    assign in_flit[3] = west_i;
    assign in_flit[4] = local_i;
    assign in_vld  = {valid_l_i, valid_w_i, valid_e_i, valid_s_i, valid_n_i};
    assign out_rdy = {ready_l_i, ready_w_i, ready_e_i, ready_s_i, ready_n_i};

    // One-hot output request in N,S,E,W,L bit order; X is resolved before Y.
    function automatic logic [4:0] route(input logic [2:0] dx, input logic [2:0] dy);
        logic [4:0] r;
        if (dx > MY_X)      r = 5'b00100;
        else if (dx < MY_X) r = 5'b01000;
        else if (dy > MY_Y) r = 5'b00001;
        else if (dy < MY_Y) r = 5'b00010;
        else                r = 5'b10000;
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            req_oh[i] = in_vld[i] ? route(in_flit[i][15:13], in_flit[i][12:10]) : 5'b00000;
        end
    end

    assign can_load = ~out_vld | out_rdy;

    always_comb begin
        logic [3:0] cand;
        cand = 4'd0;
        for (int o = 0; o < 5; o++) begin
            gnt_vld[o] = 1'b0;
            gnt_idx[o] = 3'd0;
            for (int k = 0; k < 5; k++) begin
                cand = {1'b0, rr_ptr[o]} + 4'(k);
                if (cand >= 4'd5) cand = cand - 4'd5;
                if (!gnt_vld[o] && can_load[o] && req_oh[cand[2:0]][o]) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = cand[2:0];
                end
            end
        end
    end

    // Each input requests a single output, so OR-ing grants yields at most one pop per input.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            pop_c[i] = 1'b0;
            for (int o = 0; o < 5; o++) begin
                if (gnt_vld[o] && gnt_idx[o] == 3'(i)) pop_c[i] = 1'b1;
            end
        end
        if (rst) pop_c = 5'b00000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 5'b00000;
            for (int o = 0; o < 5; o++) begin
                out_dat[o] <= 16'h0000;
                rr_ptr[o]  <= 3'd0;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (gnt_vld[o]) begin
                    out_dat[o] <= in_flit[gnt_idx[o]];
                    out_vld[o] <= 1'b1;
                    rr_ptr[o]  <= (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
                end else if (out_rdy[o]) begin
                    out_vld[o] <= 1'b0;
                end
            end
        end
    end

    assign pop_req_n_o = pop_c[0];
    assign pop_req_s_o = pop_c[1];
    assign pop_req_e_o = pop_c[2];
    assign pop_req_w_o = pop_c[3];
    assign pop_req_l_o = pop_c[4];

    assign north_o = out_dat[0];
    assign south_o = out_dat[1];
    assign east_o  = out_dat[2];
    assign west_o  = out_dat[3];
    assign local_o = out_dat[4];

    assign valid_n_o = out_vld[0];
    assign valid_s_o = out_vld[1];
    assign valid_e_o = out_vld[2];
    assign valid_w_o = out_vld[3];
    assign valid_l_o = out_vld[4];

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator at router (1,1): reset, routing, contention, backpressure, parallel grants, mid-stream reset.
module tb_switch_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] north_i, south_i, east_i, west_i, local_i;
    logic        valid_n_i, valid_s_i, valid_e_i, valid_w_i, valid_l_i;
    logic        pop_req_n_o, pop_req_s_o, pop_req_e_o, pop_req_w_o, pop_req_l_o;
    logic [15:0] north_o, south_o, east_o, west_o, local_o;
    logic        valid_n_o, valid_s_o, valid_e_o, valid_w_o, valid_l_o;
    logic        ready_n_i, ready_s_i, ready_e_i, ready_w_i, ready_l_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    switch_allocator #(.X_ID(1), .Y_ID(1)) dut (
        .clk(clk), .rst(rst),
        .north_i(north_i), .south_i(south_i), .east_i(east_i), .west_i(west_i), .local_i(local_i),
        .valid_n_i(valid_n_i), .valid_s_i(valid_s_i), .valid_e_i(valid_e_i),
        .valid_w_i(valid_w_i), .valid_l_i(valid_l_i),
        .pop_req_n_o(pop_req_n_o), .pop_req_s_o(pop_req_s_o), .pop_req_e_o(pop_req_e_o),
        .pop_req_w_o(pop_req_w_o), .pop_req_l_o(pop_req_l_o),
        .north_o(north_o), .south_o(south_o), .east_o(east_o), .west_o(west_o), .local_o(local_o),
        .valid_n_o(valid_n_o), .valid_s_o(valid_s_o), .valid_e_o(valid_e_o),
        .valid_w_o(valid_w_o), .valid_l_o(valid_l_o),
        .ready_n_i(ready_n_i), .ready_s_i(ready_s_i), .ready_e_i(ready_e_i),
        .ready_w_i(ready_w_i), .ready_l_i(ready_l_i)
    );

    wire [4:0]  pops = {pop_req_l_o, pop_req_w_o, pop_req_e_o, pop_req_s_o, pop_req_n_o};
    wire [4:0]  vo   = {valid_l_o, valid_w_o, valid_e_o, valid_s_o, valid_n_o};
    wire [79:0] dat  = {local_o, west_o, east_o, south_o, north_o};

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        {ready_n_i, ready_s_i, ready_e_i, ready_w_i, ready_l_i} = 5'b11111;
        north_i = 16'h2401; south_i = 16'h4555; east_i = 16'h0033; west_i = 16'h2811; local_i = 16'h2000;
        {valid_n_i, valid_s_i, valid_e_i, valid_w_i, valid_l_i} = 5'b11111;

        // Reset with every FIFO non-empty
        tick(); tick(); #1;
        check("rst_pop", 80'(pops), 80'h0);
        check("rst_valid", 80'(vo), 80'h0);
        check("rst_data", dat, 80'h0);

        // Single flit local -> east
        {valid_n_i, valid_s_i, valid_e_i, valid_w_i, valid_l_i} = 5'b00000;
        rst = 1'b0;
        tick();
        local_i = 16'h4555; valid_l_i = 1'b1; #1;
        check("single_pop", 80'(pops), 80'h10);
        tick();
        valid_l_i = 1'b0; #1;
        check("single_valid", 80'(vo), 80'h04);
        check("single_east", 80'(east_o), 80'h4555);
        check("single_nopop", 80'(pops), 80'h0);
        tick(); #1;
        check("single_drain", 80'(vo), 80'h0);

        // Four inputs contend for local, pointer at N
        north_i = 16'h2401; south_i = 16'h2402; east_i = 16'h2403; west_i = 16'h2404;
        {valid_n_i, valid_s_i, valid_e_i, valid_w_i} = 4'b1111; #1;
        check("cont_pop_n", 80'(pops), 80'h01);
        tick();
        valid_n_i = 1'b0; #1;
        check("cont_out_n", 80'({valid_l_o, local_o}), 80'h1_2401);
        check("cont_pop_s", 80'(pops), 80'h02);
        tick();
        valid_s_i = 1'b0; #1;
        check("cont_out_s", 80'({valid_l_o, local_o}), 80'h1_2402);
        check("cont_pop_e", 80'(pops), 80'h04);
        tick();
        valid_e_i = 1'b0; #1;
        check("cont_out_e", 80'({valid_l_o, local_o}), 80'h1_2403);
        check("cont_pop_w", 80'(pops), 80'h08);
        tick();
        valid_w_i = 1'b0; #1;
        check("cont_out_w", 80'({valid_l_o, local_o}), 80'h1_2404);
        check("cont_pop_none", 80'(pops), 80'h0);
        tick(); #1;
        check("cont_drain", 80'(vo), 80'h0);

        // Backpressure on east with a second requester queued
        ready_e_i = 1'b0;
        local_i = 16'h4555; valid_l_i = 1'b1; #1;
        check("bp_first_pop", 80'(pops), 80'h10);
        tick();
        local_i = 16'h4456; north_i = 16'h4401; valid_n_i = 1'b1; #1;
        check("bp_hold0", 80'({valid_e_o, east_o}), 80'h1_4555);
        check("bp_nopop0", 80'(pops), 80'h0);
        tick(); #1;
        check("bp_hold1", 80'({valid_e_o, east_o}), 80'h1_4555);
        check("bp_nopop1", 80'(pops), 80'h0);
        ready_e_i = 1'b1; #1;
        check("bp_release_pop_n", 80'(pops), 80'h01);
        tick();
        valid_n_i = 1'b0; #1;
        check("bp_out_n", 80'({valid_e_o, east_o}), 80'h1_4401);
        check("bp_pop_l", 80'(pops), 80'h10);
        tick();
        valid_l_i = 1'b0; #1;
        check("bp_out_l", 80'({valid_e_o, east_o}), 80'h1_4456);
        tick(); #1;
        check("bp_drain", 80'(vo), 80'h0);

        // Five inputs to five distinct outputs
        north_i = 16'h2011; south_i = 16'h2812; east_i = 16'h0013; west_i = 16'h4414; local_i = 16'h2415;
        {valid_n_i, valid_s_i, valid_e_i, valid_w_i, valid_l_i} = 5'b11111; #1;
        check("par_pops", 80'(pops), 80'h1F);
        tick();
        {valid_n_i, valid_s_i, valid_e_i, valid_w_i, valid_l_i} = 5'b00000; #1;
        check("par_valid", 80'(vo), 80'h1F);
        check("par_data", dat, {16'h2415, 16'h0013, 16'h4414, 16'h2011, 16'h2812});
        tick(); #1;
        check("par_drain", 80'(vo), 80'h0);

        // Reset after the S grant of a local contention round
        north_i = 16'h2401; south_i = 16'h2402; east_i = 16'h2403; west_i = 16'h2404;
        {valid_n_i, valid_s_i, valid_e_i, valid_w_i} = 4'b1111; #1;
        check("mrst_pop_n", 80'(pops), 80'h01);
        tick();
        valid_n_i = 1'b0; #1;
        check("mrst_pop_s", 80'(pops), 80'h02);
        tick();
        valid_s_i = 1'b0; rst = 1'b1; #1;
        check("mrst_pop_gated", 80'(pops), 80'h0);
        check("mrst_pre_out", 80'({valid_l_o, local_o}), 80'h1_2402);
        tick(); #1;
        check("mrst_valid", 80'(vo), 80'h0);
        check("mrst_data", dat, 80'h0);
        rst = 1'b0;
        north_i = 16'h2421; valid_n_i = 1'b1; #1;
        check("mrst_restart_n", 80'(pops), 80'h01);
        tick();
        valid_n_i = 1'b0; #1;
        check("mrst_out_n", 80'({valid_l_o, local_o}), 80'h1_2421);
        check("mrst_pop_e", 80'(pops), 80'h04);
        tick();
        valid_e_i = 1'b0; #1;
        check("mrst_out_e", 80'({valid_l_o, local_o}), 80'h1_2403);
        check("mrst_pop_w", 80'(pops), 80'h08);
        tick();
        valid_w_i = 1'b0; #1;
        check("mrst_out_w", 80'({valid_l_o, local_o}), 80'h1_2404);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Router stage directly downstream of the five per-port input FIFOs. Each cycle it takes the head flit of every non-empty input FIFO and computes the output port with dimension-ordered XY routing. It arbitrates round-robin per output port, issues the pop to each winning FIFO, and registers the winning flits into five single-entry output registers with valid/ready handshakes toward the links.

## Interface
Parameters:
- X_ID, default 0, router x coordinate (3 bits used).
- Y_ID, default 0, router y coordinate (3 bits used).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- north_i, south_i, east_i, west_i, local_i  input  16 each  head flit of the corresponding input FIFO.
- valid_n_i, valid_s_i, valid_e_i, valid_w_i, valid_l_i  input  1 each  FIFO non-empty; head flit is valid.
- pop_req_n_o, pop_req_s_o, pop_req_e_o, pop_req_w_o, pop_req_l_o  output  1 each  pop the head of that FIFO at this clock edge.
- north_o, south_o, east_o, west_o, local_o  output  16 each  registered output flits.
- valid_n_o, valid_s_o, valid_e_o, valid_w_o, valid_l_o  output  1 each  output register holds a flit.
- ready_n_i, ready_s_i, ready_e_i, ready_w_i, ready_l_i  input  1 each  downstream accepts the flit this cycle.

## Operation
- Port index order is N=0, S=1, E=2, W=3, L=4, used for arbitration and pointers.
- Flit format:
  - [15:13] dest x.
  - [12:10] dest y.
  - [9:0] payload, passed unmodified.
- Single-flit packets. No wormhole locking.
- Route computation, combinational per valid input:
  - dx > X_ID → E.
  - dx < X_ID → W.
  - otherwise dy > Y_ID → N.
  - otherwise dy < Y_ID → S.
  - otherwise → L.
  - Routing back to the arrival port is legal and gets no special handling.
- Output register `o` can load when !valid_o || ready_i.
- When output `o` can load:
  - Among inputs requesting `o`, grant the first requester found starting at rr_ptr[o] and scanning upward mod 5.
  - Assert that input's pop_req_*_o in the same cycle, combinationally.
  - Load the flit into the register; valid_o = 1 next cycle.
  - Set rr_ptr[o] = (winner+1) mod 5.
- When output `o` cannot load, or has no requester:
  - No grant and no pop.
  - rr_ptr[o] unchanged.
  - If it cannot load, data and valid are held stable.
- If ready_i is high and there is no new grant, valid_o clears next cycle.
- Each input requests exactly one output, so at most one pop per input per cycle. Up to five grants per cycle when destinations are distinct.
- A losing input keeps its head and retries the next cycle, with no pop.
- pop_req_*_o is never asserted while the matching valid_*_i is low.

## Timing
- Reset (rst high at a clock edge):
  - All valid_*_o = 0.
  - All data outputs = 16'h0000.
  - All rr_ptr = 0.
  - pop_req_*_o = 0 while rst is high, regardless of inputs.
- Latency: head valid and granted in cycle t → flit on output with valid at cycle t+1.
- Throughput: 1 flit/cycle per output when ready is held high.
- pop_req_*_o depends combinationally on valid_*_i, head flits, ready_*_i and state. There is no combinational path from inputs to data or valid outputs.
- Backpressure:
  - While valid_o && !ready_i, output data is frozen.
  - Competing inputs stall without popping.
- Simultaneous events: if ready_i is high and a new grant occurs in the same cycle, the register is replaced. No bubble, no duplicate.
- Reset mid-operation:
  - Flits held in output registers are discarded.
  - FIFO contents are not popped during reset.
  - Arbitration restarts with N highest priority.

## Test plan
- Reset: assert rst with all valid_*_i = 1 → all valid_*_o = 0, all outputs 16'h0000, no pop_req asserted.
- Single route (X_ID=1, Y_ID=1): local_i = {3'd2,3'd1,10'h155}, valid_l_i = 1, all ready = 1 → pop_req_l_o = 1 in cycle 0; east_o = 16'h4555 with valid_e_o = 1 in cycle 1.
- Contention: N, S, E, W all headed for local (dest 1,1), held valid, ready_l_i = 1 → grants in order N, S, E, W, one per cycle, each popped once, valid_l_o high for 4 consecutive cycles.
- Backpressure: ready_e_i = 0 with valid_e_o = 1 and a new request pending → east_o stable, no pop. Raise ready_e_i → new flit appears the next cycle.
- Parallel: five inputs to five distinct outputs in one cycle → all five pops in the same cycle, all five valid_*_o high the next cycle.
- Reset mid-stream: rst during the contention test after W... grant of S → outputs clear, and the next arbitration for local starts at N.
